// File: rtl/glitch_sweeper.sv
// Glitch delay sweeper: steps a trigger delay across a configured range, arming
// the trigger/success detectors for a number of attempts at each delay point.
module glitch_sweeper #(
  parameter int unsigned TRIG_TIMEOUT   = 48000000,
  parameter int unsigned SUCCESS_WINDOW = 480000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] delay_min,
  input  logic [31:0] delay_max,
  input  logic [15:0] delay_step,
  input  logic [7:0]  attempts,
  input  logic        trigger,
  input  logic        success,
  output logic [31:0] delay,
  output logic        set_delay,
  output logic        trigger_arm,
  output logic        success_arm,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_delay,
  output logic [15:0] miss_count
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_TRIG, WAIT_SUCC, NEXT, DONE} state_t;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_TIMEOUT - 1);
  localparam logic [31:0] SUCC_LAST = 32'(SUCCESS_WINDOW - 1);

  state_t      state_q, state_d;
  logic [31:0] cur_q, cur_d, max_q, max_d, cnt_q, cnt_d;
  logic [15:0] step_q, step_d, miss_q, miss_d;
  logic [7:0]  att_q, att_d, attempt_q, attempt_d, att_last;
  logic [31:0] delay_q, delay_d, found_delay_q, found_delay_d;
  logic        set_delay_q, set_delay_d, trig_arm_q, trig_arm_d;
  logic        succ_arm_q, succ_arm_d, busy_q, busy_d, done_q, done_d;
  logic        found_q, found_d;
  logic [32:0] sum;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    max_d         = max_q;
    step_d        = step_q;
    att_d         = att_q;
    attempt_d     = attempt_q;
    cnt_d         = cnt_q;
    miss_d        = miss_q;
    found_d       = found_q;
    found_delay_d = found_delay_q;
    sum           = {1'b0, cur_q} + {17'b0, step_q};
    att_last      = (att_q == 8'd0) ? 8'd0 : att_q - 8'd1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          max_d   = delay_max;
          step_d  = delay_step;
          att_d   = attempts;
          found_d = 1'b0;
          if (delay_min <= delay_max && delay_step != 16'd0) begin
            cur_d         = delay_min;
            attempt_d     = 8'd0;
            miss_d        = 16'd0;
            found_delay_d = 32'd0;
            state_d       = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        cnt_d   = 32'd0;
        state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        // trigger beats a coincident timeout
        if (trigger) begin
          cnt_d   = 32'd0;
          state_d = WAIT_SUCC;
        end else if (cnt_q == TRIG_LAST) begin
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_SUCC: begin
        if (success) begin
          found_d       = 1'b1;
          found_delay_d = cur_q;
          state_d       = DONE;
        end else if (cnt_q == SUCC_LAST) begin
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      NEXT: begin
        if (attempt_q < att_last) begin
          attempt_d = attempt_q + 8'd1;
          state_d   = LOAD;
        end else begin
          attempt_d = 8'd0;
          // 33-bit sum catches wrap past 0xFFFFFFFF
          if (sum[32] || sum[31:0] > max_q) begin
            state_d = DONE;
          end else begin
            cur_d   = sum[31:0];
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = IDLE;
      miss_d        = miss_q;
      found_d       = found_q;
      found_delay_d = found_delay_q;
    end

    set_delay_d = (state_d == LOAD);
    delay_d     = (state_d == LOAD) ? cur_d : delay_q;
    trig_arm_d  = (state_d == WAIT_TRIG);
    succ_arm_d  = (state_d == WAIT_SUCC);
    busy_d      = (state_d == LOAD) || (state_d == WAIT_TRIG) ||
                  (state_d == WAIT_SUCC) || (state_d == NEXT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      max_q         <= '0;
      step_q        <= '0;
      att_q         <= '0;
      attempt_q     <= '0;
      cnt_q         <= '0;
      miss_q        <= '0;
      found_q       <= 1'b0;
      found_delay_q <= '0;
      delay_q       <= '0;
      set_delay_q   <= 1'b0;
      trig_arm_q    <= 1'b0;
      succ_arm_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      max_q         <= max_d;
      step_q        <= step_d;
      att_q         <= att_d;
      attempt_q     <= attempt_d;
      cnt_q         <= cnt_d;
      miss_q        <= miss_d;
      found_q       <= found_d;
      found_delay_q <= found_delay_d;
      delay_q       <= delay_d;
      set_delay_q   <= set_delay_d;
      trig_arm_q    <= trig_arm_d;
      succ_arm_q    <= succ_arm_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign delay       = delay_q;
  assign set_delay   = set_delay_q;
  assign trigger_arm = trig_arm_q;
  assign success_arm = succ_arm_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_delay = found_delay_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_glitch_sweeper.sv
// Bench for glitch_sweeper: expected set_delay values are queued as each sweep
// is launched and popped by a monitor on every set_delay pulse.
module tb_glitch_sweeper;
  localparam int TT = 8;
  localparam int SW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, trigger = 1'b0, success = 1'b0;
  logic [31:0] delay_min = '0, delay_max = '0;
  logic [15:0] delay_step = '0;
  logic [7:0]  attempts = '0;
  logic [31:0] delay, found_delay;
  logic        set_delay, trigger_arm, success_arm, busy, done, found;
  logic [15:0] miss_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  glitch_sweeper #(.TRIG_TIMEOUT(TT), .SUCCESS_WINDOW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
    .attempts(attempts), .trigger(trigger), .success(success),
    .delay(delay), .set_delay(set_delay), .trigger_arm(trigger_arm),
    .success_arm(success_arm), .busy(busy), .done(done), .found(found),
    .found_delay(found_delay), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // scoreboard: each set_delay pulse must match the oldest queued delay
  always @(negedge clk) begin
    if (rst && set_delay) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL set_delay_unexpected delay=%h", delay);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (delay !== e) begin
          failures++;
          $display("FAIL set_delay_value got=%h exp=%h", delay, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] mn, input logic [31:0] mx,
                        input logic [15:0] st, input logic [7:0] at);
    delay_min = mn; delay_max = mx; delay_step = st; attempts = at;
    start = 1'b1;
    tick();
    start = 1'b0;
    // scrambled config must not affect the running sweep
    delay_min = 32'h1234_5678; delay_max = 32'h0; delay_step = 16'h1; attempts = 8'd9;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_tarm(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (trigger_arm) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_sarm(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (success_arm) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({delay, set_delay, trigger_arm, success_arm, busy, done, found, found_delay, miss_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {delay, set_delay, trigger_arm, success_arm, busy, done, found, found_delay, miss_count});
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sweep_no_trig();
    bit ok;
    exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd30);
    launch(32'd10, 32'd30, 16'd10, 8'd1);
    checks++;
    if (!(busy === 1'b1 && set_delay === 1'b1)) begin
      failures++;
      $display("FAIL sweep_start busy=%b set_delay=%b exp=1,1", busy, set_delay);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sweep_done_timeout done=%b exp=1", done); end
    checks++;
    if (found !== 1'b0 || miss_count !== 16'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_result found=%b miss=%0d busy=%b exp=0,3,0", found, miss_count, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sweep_points left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_success();
    bit ok;
    exp_q.push_back(32'd5); exp_q.push_back(32'd5);
    launch(32'd5, 32'd5, 16'd1, 8'd3);
    // attempt 1: trigger, let the success window lapse
    wait_tarm(20, ok);
    trigger = 1'b1; tick(); trigger = 1'b0;
    checks++;
    if (!ok || trigger_arm !== 1'b0 || success_arm !== 1'b1) begin
      failures++;
      $display("FAIL succ_trig1 ok=%b tarm=%b sarm=%b exp=1,0,1", ok, trigger_arm, success_arm);
    end
    for (int i = 0; i < SW; i++) tick();
    checks++;
    if (success_arm !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL succ_window sarm=%b busy=%b exp=0,1", success_arm, busy);
    end
    // attempt 2: trigger then success
    wait_tarm(20, ok);
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_sarm(5, ok);
    success = 1'b1; tick(); success = 1'b0;
    checks++;
    if (!ok || done !== 1'b1 || found !== 1'b1 || found_delay !== 32'd5 || busy !== 1'b0 || miss_count !== 16'd0) begin
      failures++;
      $display("FAIL succ_found ok=%b done=%b found=%b fd=%0d busy=%b miss=%0d exp=1,1,1,5,0,0",
               ok, done, found, found_delay, busy, miss_count);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL succ_points left=%0d exp=0", exp_q.size()); end
    // success outside WAIT_SUCC is ignored; done holds
    success = 1'b1; tick(); success = 1'b0; tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL succ_hold done=%b busy=%b exp=1,0", done, busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    exp_q.push_back(32'hFFFF_FFF0);
    launch(32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'h20, 8'd1);
    wait_done(100, ok);
    checks++;
    if (!ok || found !== 1'b0 || miss_count !== 16'd1 || delay !== 32'hFFFF_FFF0) begin
      failures++;
      $display("FAIL overflow ok=%b found=%b miss=%0d delay=%h exp=1,0,1,fffffff0", ok, found, miss_count, delay);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL overflow_points left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_invalid();
    logic any_out;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) launch(32'd1, 32'd9, 16'd0, 8'd1);
      else        launch(32'd9, 32'd1, 16'd1, 8'd1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || found !== 1'b0) begin
        failures++;
        $display("FAIL invalid_%0d done=%b busy=%b found=%b exp=1,0,0", k, done, busy, found);
      end
      any_out = set_delay | trigger_arm | success_arm;
      for (int i = 0; i < 4; i++) begin
        tick();
        any_out = any_out | set_delay | trigger_arm | success_arm;
      end
      checks++;
      if (any_out !== 1'b0) begin
        failures++;
        $display("FAIL invalid_arms_%0d got=%b exp=0", k, any_out);
      end
    end
  endtask

  task automatic test_tie_abort();
    bit ok;
    exp_q.push_back(32'd1);
    launch(32'd1, 32'd1, 16'd1, 8'd1);
    wait_tarm(20, ok);
    for (int i = 0; i < TT - 1; i++) tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    checks++;
    if (!ok || success_arm !== 1'b1 || trigger_arm !== 1'b0 || miss_count !== 16'd0) begin
      failures++;
      $display("FAIL tie ok=%b sarm=%b tarm=%b miss=%0d exp=1,1,0,0", ok, success_arm, trigger_arm, miss_count);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (success_arm !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || miss_count !== 16'd0) begin
      failures++;
      $display("FAIL abort sarm=%b busy=%b done=%b miss=%0d exp=0,0,0,0", success_arm, busy, done, miss_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || set_delay !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b set_delay=%b exp=0,0", busy, set_delay);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_q.push_back(32'd2);
    launch(32'd2, 32'd2, 16'd1, 8'd1);
    wait_tarm(20, ok);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (!ok || {delay, set_delay, trigger_arm, success_arm, busy, done, found, found_delay, miss_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid ok=%b tarm=%b busy=%b delay=%h exp=1,0,0,0", ok, trigger_arm, busy, delay);
    end
    rst = 1'b1;
    exp_q.push_back(32'd7);
    launch(32'd7, 32'd7, 16'd3, 8'd1);
    checks++;
    if (busy !== 1'b1 || set_delay !== 1'b1 || delay !== 32'd7) begin
      failures++;
      $display("FAIL reset_restart busy=%b set_delay=%b delay=%0d exp=1,1,7", busy, set_delay, delay);
    end
    wait_done(100, ok);
    checks++;
    if (!ok || found !== 1'b0 || miss_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_rerun ok=%b found=%b miss=%0d exp=1,0,1", ok, found, miss_count);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL reset_points left=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sweep_no_trig();
    test_success();
    test_overflow();
    test_invalid();
    test_tie_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glitch_sweeper.md
GLITCH_SWEEPER -- requirements
Module: glitch_sweeper

Interface
REQ-001 SHALL have parameter TRIG_TIMEOUT, default 48000000, meaning clk cycles to wait for trigger per attempt (1 s at 48 MHz).
REQ-002 SHALL have parameter SUCCESS_WINDOW, default 480000, meaning clk cycles success_arm stays high after a trigger (10 ms).
REQ-003 SHALL have port clk  input  1  system clock, 48 MHz; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins a sweep when idle or done.
REQ-006 SHALL have port abort  input  1  level; forces return to IDLE.
REQ-007 SHALL have ports delay_min, delay_max  input  32 each  sweep bounds in target-clock cycles, inclusive.
REQ-008 SHALL have port delay_step  input  16  increment between delay points.
REQ-009 SHALL have port attempts  input  8  glitch attempts per delay point; 0 is treated as 1.
REQ-010 SHALL have ports trigger, success  input  1 each  single-cycle pulses from the edge detectors.
REQ-011 SHALL have port delay  output  32  delay value for the trigger-delay stage.
REQ-012 SHALL have ports set_delay, trigger_arm, success_arm  output  1 each  load strobe and detector arms.
REQ-013 SHALL have ports busy, done, found  output  1 each  status flags.
REQ-014 SHALL have ports found_delay  output  32, and miss_count  output  16  (attempts ending with no trigger).

Function
REQ-015 SHALL sample configuration inputs only on the accepted start edge; changes during a sweep SHALL be ignored.
REQ-016 SHALL implement states IDLE, LOAD, WAIT_TRIG, WAIT_SUCC, NEXT, DONE; all outputs SHALL be registered.
REQ-017 IDLE/DONE: start with delay_min<=delay_max and delay_step!=0 -> LOAD, cur=delay_min, attempt=0; found, miss_count and found_delay cleared.
REQ-018 IDLE/DONE: start with an invalid configuration -> DONE; found=0; no set_delay or arm is issued.
REQ-019 LOAD: delay=cur and set_delay high for exactly one cycle, beginning the cycle after start; then -> WAIT_TRIG.
REQ-020 WAIT_TRIG: trigger_arm high and cycle counter running; trigger -> WAIT_SUCC with trigger_arm low from the next cycle; counter reaching TRIG_TIMEOUT-1 -> NEXT with miss_count+1 (saturating at 0xFFFF).
REQ-021 WAIT_SUCC: success_arm high for at most SUCCESS_WINDOW cycles; success -> DONE with found=1 and found_delay=cur; window expiry -> NEXT.
REQ-022 success outside WAIT_SUCC and trigger outside WAIT_TRIG SHALL be ignored.
REQ-023 If trigger and timeout occur in the same cycle, trigger SHALL win; if success and window expiry coincide, success SHALL win.
REQ-024 NEXT (one cycle) when attempt < max(attempts,1)-1: attempt+1, then -> LOAD with the same cur.
REQ-025 NEXT otherwise: attempt=0 and cur+delay_step computed in 33 bits; if the result > delay_max or overflows, -> DONE with found=0; else -> LOAD with cur updated.
REQ-026 busy SHALL be high in LOAD, WAIT_TRIG, WAIT_SUCC and NEXT; done SHALL be high only in DONE and hold until start or abort.
REQ-027 abort SHALL take priority over every transition: next state IDLE, arms and set_delay low the next cycle, found and miss_count held.
REQ-028 start while busy SHALL be ignored.

Reset
REQ-029 While rst=0, state SHALL be IDLE and all outputs 0; rst assertion mid-sweep SHALL drop arms and set_delay asynchronously.
REQ-030 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-031 min=10, max=30, step=10, attempts=1, no trigger, small TRIG_TIMEOUT -> set_delay pulses with delay 10, 20, 30; done=1, found=0, miss_count=3.
REQ-032 min=5, max=5, attempts=3, trigger each attempt, success on the 2nd attempt -> two set_delay pulses, found=1, found_delay=5, done=1.
REQ-033 min=0xFFFFFFF0, max=0xFFFFFFFF, step=0x20 -> one delay point, then DONE with no wrap to a low delay.
REQ-034 step=0 or min>max -> done the cycle after start; set_delay, trigger_arm and success_arm never asserted.
REQ-035 trigger and timeout in the same cycle -> WAIT_SUCC entered and miss_count unchanged; abort during WAIT_SUCC -> success_arm low next cycle, busy=0.
REQ-036 rst pulse low during WAIT_TRIG -> trigger_arm=0 immediately and all outputs 0; a new start after release runs normally.
